demux_collector: RTL and testbench

//  Inverse of the mux: takes a 1-bit stream and routes each bit to one of M=2**N

---
 rtl/demux_collector_pkg.sv | 13 +
 rtl/demux_collector_decoder.sv | 16 +
 rtl/demux_collector.sv | 84 ++++++++
 tb/tb_demux_collector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/demux_collector_pkg.sv
// Shared definitions for the 1-to-M bit demux collector.
package demux_collector_pkg;

   // Default number of select lines; the word width is 2**N.
   localparam int DEF_N = 4;

   // COLLECT accepts bits, HOLD presents the completed word.
   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/demux_collector_decoder.sv
// N-bit index to M-bit one-hot write-enable decoder.
module demux_decoder #(
   parameter  int N = 4,
   localparam int M = 2**N
) (
   input  logic [N-1:0] idx,
   output logic [M-1:0] onehot
);

   // Exactly one bit set, at the addressed position.
   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/demux_collector.sv
// Routes a 1-bit stream into positions of an M-bit word (explicit select or
// auto-counter), then holds the completed word on a valid/ready output.
module demux_collector
   import demux_collector_pkg::*;
#(
   parameter  int N = DEF_N,
   localparam int M = 2**N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_bit,
   input  logic         sel_mode,
   input  logic [N-1:0] sel,
   output logic [M-1:0] out_word,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] wr_ptr
);

   state_t       state;
   logic [M-1:0] filled;
   logic [M-1:0] wen;
   logic [M-1:0] fill_next;
   logic [N-1:0] idx;
   logic         wr;

   // A write only happens while collecting; in_ready is low in HOLD.
   assign wr        = in_valid & in_ready;
   assign idx       = sel_mode ? sel : wr_ptr;
   assign fill_next = filled | wen;

   demux_decoder #(.N(N)) u_decoder (
      .idx    (idx),
      .onehot (wen)
   );

   // State, word, mask and pointer; handshake outputs are registered so
   // out_ready never reaches in_ready combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         out_word  <= '0;
         filled    <= '0;
         wr_ptr    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (wr) begin
                  out_word[idx] <= in_bit;
                  filled        <= fill_next;
                  if (!sel_mode) wr_ptr <= wr_ptr + 1'b1;
                  // Completion is decided by the mask alone, so repeated
                  // explicit writes to one position never count twice.
                  if (&fill_next) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= COLLECT;
                  out_word  <= '0;
                  filled    <= '0;
                  wr_ptr    <= '0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= COLLECT;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_demux_collector.sv
// Scoreboard bench for demux_collector.
module tb_demux_collector;

   localparam int N = 4;
   localparam int M = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         in_bit;
   logic         sel_mode;
   logic [N-1:0] sel;
   logic [M-1:0] out_word;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] wr_ptr;

   demux_collector #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .sel_mode  (sel_mode),
      .sel       (sel),
      .out_word  (out_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wr_ptr    (wr_ptr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic         m_hold;
   logic [M-1:0] m_word;
   logic [M-1:0] m_filled;
   logic [N-1:0] m_ptr;
   logic [M-1:0] exp_q[$];
   int           words_out;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic mux(input logic [M-1:0] w, input logic [N-1:0] s);
      return w[s];
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ~m_hold});
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_hold});
      check({tag, ".wr_ptr"},    {28'd0, wr_ptr},    {28'd0, m_ptr});
      check({tag, ".out_word"},  {16'd0, out_word},  {16'd0, m_word});
   endtask

   task automatic model_reset();
      m_hold   = 1'b0;
      m_word   = '0;
      m_filled = '0;
      m_ptr    = '0;
      exp_q.delete();
   endtask

   // One clock cycle: drive at negedge, advance the model, check at next negedge.
   task automatic step(input logic v, input logic b, input logic md,
                       input logic [N-1:0] s, input logic ordy, input string tag);
      logic [N-1:0] k;
      in_valid  = v;
      in_bit    = b;
      sel_mode  = md;
      sel       = s;
      out_ready = ordy;
      if (m_hold) begin
         if (ordy) begin
            if (exp_q.size() == 0) begin
               check({tag, ".q_empty"}, 32'd1, 32'd0);
            end else begin
               check({tag, ".accepted_word"}, {16'd0, out_word}, {16'd0, exp_q.pop_front()});
            end
            words_out++;
            m_hold   = 1'b0;
            m_word   = '0;
            m_filled = '0;
            m_ptr    = '0;
         end
      end else if (v) begin
         k           = md ? s : m_ptr;
         m_word[k]   = b;
         m_filled[k] = 1'b1;
         if (!md) m_ptr = m_ptr + 1'b1;
         if (&m_filled) begin
            m_hold = 1'b1;
            exp_q.push_back(m_word);
         end
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_outputs("reset");
   endtask

   logic [M-1:0] pat;

   initial begin
      rst = 1'b1; in_valid = 0; in_bit = 0; sel_mode = 0; sel = '0; out_ready = 0;
      words_out = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      do_reset();
      check("rst.out_word", {16'd0, out_word}, 32'd0);

      // 1: auto writes of D7A5
      pat = 16'hD7A5;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, pat[i], 1'b0, 4'd0, 1'b0, "t1");
         if (i < 15) check("t1.not_done", {31'd0, out_valid}, 32'd0);
      end
      check("t1.valid",  {31'd0, out_valid}, 32'd1);
      check("t1.word",   {16'd0, out_word}, 32'hD7A5);
      check("t1.wr_ptr", {28'd0, wr_ptr}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "t1a");

      // 2: explicit writes giving 8421, loopback
      for (int i = 0; i < 16; i++)
         step(1'b1, (i % 5) == 0, 1'b1, 4'(i), 1'b0, "t2");
      check("t2.word", {16'd0, out_word}, 32'h8421);
      check("t2.mux5", {31'd0, mux(out_word, 4'd5)}, 32'd1);
      check("t2.mux4", {31'd0, mux(out_word, 4'd4)}, 32'd0);
      check("t2.ptr_unchanged", {28'd0, wr_ptr}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "t2a");

      // 3: duplicate index at 3
      step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, "t3");
      step(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, "t3");
      for (int i = 0; i < 15; i++)
         if (i != 3) step(1'b1, 1'b1, 1'b1, 4'(i), 1'b0, "t3");
      check("t3.not_done16", {31'd0, out_valid}, 32'd0);
      step(1'b1, 1'b1, 1'b1, 4'd15, 1'b0, "t3");
      check("t3.done17", {31'd0, out_valid}, 32'd1);
      check("t3.bit3",   {31'd0, out_word[3]}, 32'd0);

      // 4: hold with in_valid high, then release
      pat = out_word;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, "t4");
         check("t4.frozen", {16'd0, out_word}, {16'd0, pat});
      end
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "t4rel");
      check("t4.in_ready", {31'd0, in_ready}, 32'd1);
      check("t4.cleared",  {16'd0, out_word}, 32'd0);

      // 5: reset mid-word, then 4AF2
      in_valid = 1'b0;
      pat = 16'hFFFF;
      for (int i = 0; i < 7; i++) step(1'b1, pat[i], 1'b0, 4'd0, 1'b0, "t5pre");
      do_reset();
      check("t5.word0", {16'd0, out_word}, 32'd0);
      check("t5.ptr0",  {28'd0, wr_ptr}, 32'd0);
      pat = 16'h4AF2;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, pat[i], 1'b0, 4'd0, 1'b0, "t5");
         if (i == 14) check("t5.not_at15", {31'd0, out_valid}, 32'd0);
      end
      check("t5.done16", {31'd0, out_valid}, 32'd1);
      check("t5.word",   {16'd0, out_word}, 32'h4AF2);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "t5a");

      // 6: random gaps, mixed modes, random backpressure
      for (int i = 0; i < 1500; i++)
         step(($urandom % 3) != 0, 1'($urandom), 1'($urandom), 4'($urandom),
              ($urandom % 4) == 0, "t6");
      for (int i = 0; i < 40 && m_hold; i++)
         step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "t6drain");
      check("t6.queue_empty", exp_q.size(), 32'd0);
      check("t6.some_words", {31'd0, words_out > 8}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
